// File: rtl/watch_time_counter.sv
// Calendar/time-of-day counter for a watch: 2000..2099 with leap years,
// advanced by a synchronized 1 Hz strobe and loadable from a binary time word.
module watch_time_counter #(
  parameter logic [7:0] RST_YEAR  = 8'd0,
  parameter logic [7:0] RST_MONTH = 8'd1,
  parameter logic [7:0] RST_DAY   = 8'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk1sec,
  input  logic [47:0] bin_time,
  input  logic        en_time,
  output logic [7:0]  year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  second,
  output logic        sec_tick,
  output logic        load_err
);

  // Days in month m of year y (y = 0..99 stands for 2000..2099, so y%4 == 0 is leap).
  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [7:0] y);
    case (m)
      8'd4, 8'd6, 8'd9, 8'd11: days_in_month = 8'd30;
      8'd2:                    days_in_month = (y[1:0] == 2'b00) ? 8'd29 : 8'd28;
      default:                 days_in_month = 8'd31;
    endcase
  endfunction

  logic sync_q1, sync_q2, sync_q3;
  logic tick;

  logic [7:0] ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second;
  logic       load_ok;

  logic       c_sec, c_min, c_hour, c_day, c_month;
  logic [7:0] dim;
  logic [7:0] year_n, month_n, day_n, hour_n, minute_n, second_n;

  assign {ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second} = bin_time;

  // Two-flop synchronizer plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      sync_q3 <= 1'b0;
    end else begin
      sync_q1 <= clk1sec;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
    end
  end

  assign tick = sync_q2 & ~sync_q3;

  // Validate the load word field by field.
  always_comb begin
    load_ok = (ld_year <= 8'd99) &&
              (ld_month >= 8'd1) && (ld_month <= 8'd12) &&
              (ld_day >= 8'd1) && (ld_day <= days_in_month(ld_month, ld_year)) &&
              (ld_hour <= 8'd23) && (ld_minute <= 8'd59) && (ld_second <= 8'd59);
  end

  // Next time after one second, with the whole carry chain resolved in one cycle.
  always_comb begin
    dim      = days_in_month(month, year);
    c_sec    = (second == 8'd59);
    c_min    = c_sec  && (minute == 8'd59);
    c_hour   = c_min  && (hour == 8'd23);
    c_day    = c_hour && (day >= dim);
    c_month  = c_day  && (month == 8'd12);
    second_n = c_sec ? '0 : second + 8'd1;
    minute_n = c_sec ? (c_min ? '0 : minute + 8'd1) : minute;
    hour_n   = c_min ? (c_hour ? '0 : hour + 8'd1) : hour;
    day_n    = c_hour ? (c_day ? 8'd1 : day + 8'd1) : day;
    month_n  = c_day ? (c_month ? 8'd1 : month + 8'd1) : month;
    year_n   = c_month ? ((year == 8'd99) ? '0 : year + 8'd1) : year;
  end

  // Time registers: a load strobe takes priority and swallows any coincident tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      year     <= RST_YEAR;
      month    <= RST_MONTH;
      day      <= RST_DAY;
      hour     <= '0;
      minute   <= '0;
      second   <= '0;
      sec_tick <= 1'b0;
      load_err <= 1'b0;
    end else if (en_time) begin
      sec_tick <= 1'b0;
      load_err <= ~load_ok;
      if (load_ok) begin
        year   <= ld_year;
        month  <= ld_month;
        day    <= ld_day;
        hour   <= ld_hour;
        minute <= ld_minute;
        second <= ld_second;
      end
    end else if (tick) begin
      year     <= year_n;
      month    <= month_n;
      day      <= day_n;
      hour     <= hour_n;
      minute   <= minute_n;
      second   <= second_n;
      sec_tick <= 1'b1;
      load_err <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_watch_time_counter.sv
// Bench for watch_time_counter: table of load/tick vectors plus hand-written
// sequences for load/tick collision, async reset mid-carry and a 60 s run.
module tb_watch_time_counter;

  logic        clk;
  logic        rst;
  logic        clk1sec;
  logic [47:0] bin_time;
  logic        en_time;
  logic [7:0]  year, month, day, hour, minute, second;
  logic        sec_tick, load_err;
  logic [47:0] now;

  watch_time_counter #(
    .RST_YEAR (8'd5),
    .RST_MONTH(8'd6),
    .RST_DAY  (8'd7)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clk1sec (clk1sec),
    .bin_time(bin_time),
    .en_time (en_time),
    .year    (year),
    .month   (month),
    .day     (day),
    .hour    (hour),
    .minute  (minute),
    .second  (second),
    .sec_tick(sec_tick),
    .load_err(load_err)
  );

  assign now = {year, month, day, hour, minute, second};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ld_en;
    logic [47:0] ld;
    bit          err;
    bit          tick;
    logic [47:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [47:0] t;
    bit          err;
    bit          stk;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vt[20];
  int          n_vec = 0;
  int          n_mis = 0;
  int          stk_cnt = 0;
  int          stk_base;
  logic [47:0] cur;
  logic [47:0] rst_val;

  function automatic logic [47:0] tm(input int y, input int mo, input int d,
                                     input int h, input int mi, input int s);
    return {y[7:0], mo[7:0], d[7:0], h[7:0], mi[7:0], s[7:0]};
  endfunction

  always @(negedge clk) if (rst && sec_tick) stk_cnt++;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sbq.size() == 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sbq.pop_front();
      chk({e.name, " time"}, now, e.t);
      chk({e.name, " load_err"}, {47'd0, load_err}, {47'd0, e.err});
      chk({e.name, " sec_tick"}, {47'd0, sec_tick}, {47'd0, e.stk});
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic do_load(input string nm, input logic [47:0] ld, input bit err);
    en_time  = 1'b1;
    bin_time = ld;
    if (!err) cur = ld;
    sbq.push_back('{nm, cur, err, 1'b0});
    @(negedge clk);
    sb_pop();
    en_time = 1'b0;
    @(negedge clk);
    chk({nm, " load_err width"}, {47'd0, load_err}, 48'd0);
  endtask

  task automatic do_tick(input string nm, input logic [47:0] exp);
    clk1sec = 1'b1;
    sbq.push_back('{nm, exp, 1'b0, 1'b1});
    repeat (2) @(negedge clk);
    chk({nm, " pre-tick hold"}, now, cur);
    @(negedge clk);
    sb_pop();
    cur = exp;
    clk1sec = 1'b0;
    @(negedge clk);
    chk({nm, " sec_tick width"}, {47'd0, sec_tick}, 48'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish within 2 ms");
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    clk1sec  = 1'b0;
    en_time  = 1'b0;
    bin_time = '0;
    rst_val  = tm(5, 6, 7, 0, 0, 0);
    cur      = rst_val;

    vt[0]  = '{1'b1, tm(24, 2, 28, 23, 59, 59), 1'b0, 1'b1, tm(24, 2, 29, 0, 0, 0)};
    vt[1]  = '{1'b0, '0,                         1'b0, 1'b1, tm(24, 2, 29, 0, 0, 1)};
    vt[2]  = '{1'b1, tm(23, 2, 28, 23, 59, 59), 1'b0, 1'b1, tm(23, 3, 1, 0, 0, 0)};
    vt[3]  = '{1'b1, tm(99, 12, 31, 23, 59, 59), 1'b0, 1'b1, tm(0, 1, 1, 0, 0, 0)};
    vt[4]  = '{1'b1, tm(23, 13, 1, 0, 0, 0),    1'b1, 1'b0, tm(0, 1, 1, 0, 0, 0)};
    vt[5]  = '{1'b1, tm(23, 4, 31, 0, 0, 0),    1'b1, 1'b0, tm(0, 1, 1, 0, 0, 0)};
    vt[6]  = '{1'b1, tm(23, 0, 1, 0, 0, 0),     1'b1, 1'b0, tm(0, 1, 1, 0, 0, 0)};
    vt[7]  = '{1'b1, tm(23, 4, 0, 0, 0, 0),     1'b1, 1'b0, tm(0, 1, 1, 0, 0, 0)};
    vt[8]  = '{1'b1, tm(23, 2, 29, 0, 0, 0),    1'b1, 1'b0, tm(0, 1, 1, 0, 0, 0)};
    vt[9]  = '{1'b1, tm(100, 1, 1, 0, 0, 0),    1'b1, 1'b0, tm(0, 1, 1, 0, 0, 0)};
    vt[10] = '{1'b1, tm(23, 1, 1, 24, 0, 0),    1'b1, 1'b0, tm(0, 1, 1, 0, 0, 0)};
    vt[11] = '{1'b1, tm(23, 1, 1, 0, 60, 0),    1'b1, 1'b0, tm(0, 1, 1, 0, 0, 0)};
    vt[12] = '{1'b1, tm(23, 1, 1, 0, 0, 60),    1'b1, 1'b0, tm(0, 1, 1, 0, 0, 0)};
    vt[13] = '{1'b1, tm(0, 2, 29, 12, 34, 56),  1'b0, 1'b0, tm(0, 2, 29, 12, 34, 56)};
    vt[14] = '{1'b1, tm(24, 12, 31, 23, 59, 58), 1'b0, 1'b1, tm(24, 12, 31, 23, 59, 59)};
    vt[15] = '{1'b0, '0,                         1'b0, 1'b1, tm(25, 1, 1, 0, 0, 0)};
    vt[16] = '{1'b1, tm(21, 6, 30, 10, 59, 59), 1'b0, 1'b1, tm(21, 6, 30, 11, 0, 0)};
    vt[17] = '{1'b1, tm(21, 1, 31, 23, 59, 59), 1'b0, 1'b1, tm(21, 2, 1, 0, 0, 0)};
    vt[18] = '{1'b1, tm(21, 11, 30, 23, 59, 59), 1'b0, 1'b1, tm(21, 12, 1, 0, 0, 0)};
    vt[19] = '{1'b1, tm(96, 2, 29, 23, 59, 59), 1'b0, 1'b1, tm(96, 3, 1, 0, 0, 0)};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset time", now, rst_val);
    chk("reset flags", {46'd0, sec_tick, load_err}, 48'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle hold", now, rst_val);

    // Table-driven vectors
    for (int i = 0; i < 20; i++) begin
      if (vt[i].ld_en) do_load($sformatf("vec%0d load", i), vt[i].ld, vt[i].err);
      if (vt[i].tick)  do_tick($sformatf("vec%0d tick", i), vt[i].exp);
      chk($sformatf("vec%0d final", i), now, vt[i].exp);
    end

    // Load held over several cycles, colliding with a tick: tick discarded
    stk_base = stk_cnt;
    clk1sec  = 1'b1;
    @(negedge clk);
    en_time  = 1'b1;
    bin_time = tm(10, 5, 5, 12, 0, 0);
    cur      = bin_time;
    for (int k = 0; k < 4; k++) begin
      sbq.push_back('{$sformatf("collide cyc%0d", k), cur, 1'b0, 1'b0});
      @(negedge clk);
      sb_pop();
    end
    en_time = 1'b0;
    clk1sec = 1'b0;
    repeat (5) @(negedge clk);
    chk("collide hold", now, tm(10, 5, 5, 12, 0, 0));
    chk("collide no tick", 48'(stk_cnt - stk_base), 48'd0);

    // Asynchronous reset in the middle of a full-carry cycle
    do_load("carry load", tm(99, 12, 31, 23, 59, 59), 1'b0);
    clk1sec = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async reset time", now, rst_val);
    chk("async reset flags", {46'd0, sec_tick, load_err}, 48'd0);
    @(negedge clk);
    chk("reset held", now, rst_val);
    // clk1sec still high across release: exactly one tick expected
    stk_base = stk_cnt;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("release single tick", 48'(stk_cnt - stk_base), 48'd1);
    chk("release time", now, tm(5, 6, 7, 0, 0, 1));
    clk1sec = 1'b0;
    repeat (4) @(negedge clk);

    // Fresh reset, then 60 seconds
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cur = rst_val;
    @(negedge clk);
    stk_base = stk_cnt;
    for (int k = 1; k <= 60; k++) begin
      do_tick($sformatf("run sec%0d", k), tm(5, 6, 7, 0, k / 60, k % 60));
    end
    chk("run tick count", 48'(stk_cnt - stk_base), 48'd60);
    chk("run final", now, tm(5, 6, 7, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
